// File: rtl/issue_queue_param.sv
// Parameterised out-of-order issue queue: multi-lane dispatch into lowest free
// entries, tag-broadcast wakeup, and lowest-index oldest-slot select.
module issue_queue_param #(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 4,
  parameter int WAKE_N    = 4,
  parameter int PREG_W    = 6,
  parameter int PAY_W     = 35,
  parameter int SELF_WAKE = 1
) (
  input  logic                       Clk,
  input  logic                       Rest,
  input  logic                       IsQuStop,
  input  logic                       IsQuFlash,
  output logic                       IsQuReq,
  input  logic [DISP_W-1:0]          InValid,
  input  logic [DISP_W-1:0]          InSrc1Able,
  input  logic [DISP_W-1:0]          InSrc2Able,
  input  logic [DISP_W-1:0]          InRdAble,
  input  logic [DISP_W-1:0]          InSrc1Rdy,
  input  logic [DISP_W-1:0]          InSrc2Rdy,
  input  logic [DISP_W*PREG_W-1:0]   InSrc1Addr,
  input  logic [DISP_W*PREG_W-1:0]   InSrc2Addr,
  input  logic [DISP_W*PREG_W-1:0]   InRdAddr,
  input  logic [DISP_W*PAY_W-1:0]    InPayload,
  input  logic [WAKE_N-1:0]          WakeValid,
  input  logic [WAKE_N*PREG_W-1:0]   WakeAddr,
  input  logic                       IssReady,
  output logic                       IssValid,
  output logic [PREG_W-1:0]          IssSrc1Addr,
  output logic [PREG_W-1:0]          IssSrc2Addr,
  output logic [PREG_W-1:0]          IssRdAddr,
  output logic                       IssRdAble,
  output logic [PAY_W-1:0]           IssPayload,
  output logic [$clog2(DEPTH)-1:0]   IssEntry,
  output logic [$clog2(DEPTH):0]     Occupancy
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  s1_able;
  logic [DEPTH-1:0]  s1_rdy;
  logic [DEPTH-1:0]  s2_able;
  logic [DEPTH-1:0]  s2_rdy;
  logic [DEPTH-1:0]  rd_able;
  logic [PREG_W-1:0] s1_tag [DEPTH];
  logic [PREG_W-1:0] s2_tag [DEPTH];
  logic [PREG_W-1:0] rd_tag [DEPTH];
  logic [PAY_W-1:0]  pay    [DEPTH];
  logic [CNT_W-1:0]  occ;

  logic [DEPTH-1:0]  ent_rdy;
  logic              sel_any;
  logic [IDX_W-1:0]  sel_idx;
  logic              issue_fire;
  logic              sw_v;
  logic [PREG_W-1:0] sw_tag;

  logic              accept;
  logic [CNT_W-1:0]  free_cnt;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  lane_rank [DISP_W];
  logic [CNT_W-1:0]  free_rank [DEPTH];
  logic [DEPTH-1:0]  wr_en;
  logic [LANE_W-1:0] wr_lane   [DEPTH];

  logic [DISP_W-1:0] lane_s1_hit;
  logic [DISP_W-1:0] lane_s2_hit;
  logic [DEPTH-1:0]  ent_s1_hit;
  logic [DEPTH-1:0]  ent_s2_hit;

  function automatic logic tag_hit(
    input logic [PREG_W-1:0]        tag,
    input logic [WAKE_N-1:0]        wv,
    input logic [WAKE_N*PREG_W-1:0] wa,
    input logic                     sv,
    input logic [PREG_W-1:0]        st
  );
    logic hit;
    hit = sv && (st == tag);
    for (int w = 0; w < WAKE_N; w++) begin
      if (wv[w] && (wa[w*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // select: descending scan so the lowest ready index wins
  always_comb begin
    ent_rdy = ent_valid & (~s1_able | s1_rdy) & (~s2_able | s2_rdy);
    sel_any = 1'b0;
    sel_idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (ent_rdy[e]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(e);
      end
    end
  end

  assign IssValid    = sel_any & ~IsQuStop;
  assign issue_fire  = IssValid & IssReady;
  assign IssSrc1Addr = s1_tag[sel_idx];
  assign IssSrc2Addr = s2_tag[sel_idx];
  assign IssRdAddr   = rd_tag[sel_idx];
  assign IssRdAble   = rd_able[sel_idx];
  assign IssPayload  = pay[sel_idx];
  assign IssEntry    = sel_idx;
  assign Occupancy   = occ;

  assign sw_v   = (SELF_WAKE != 0) && issue_fire && rd_able[sel_idx];
  assign sw_tag = rd_tag[sel_idx];

  assign free_cnt = CNT_W'(DEPTH) - occ;
  assign IsQuReq  = free_cnt < CNT_W'(DISP_W);
  assign accept   = ~IsQuReq & ~IsQuStop & ~IsQuFlash;

  always_comb begin
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int l = 0; l < DISP_W; l++) begin
      lane_rank[l] = cnt;
      if (InValid[l]) cnt = cnt + 1'b1;
    end
    acc_cnt = accept ? cnt : '0;
  end

  // the k-th valid lane lands in the k-th free entry; backpressure guarantees room
  always_comb begin
    logic [CNT_W-1:0] fc;
    fc = '0;
    for (int e = 0; e < DEPTH; e++) begin
      free_rank[e] = fc;
      if (!ent_valid[e]) fc = fc + 1'b1;
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wr_en[e]   = 1'b0;
      wr_lane[e] = '0;
      for (int l = 0; l < DISP_W; l++) begin
        if (accept && InValid[l] && !ent_valid[e] && (lane_rank[l] == free_rank[e])) begin
          wr_en[e]   = 1'b1;
          wr_lane[e] = LANE_W'(l);
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < DISP_W; l++) begin
      lane_s1_hit[l] = tag_hit(InSrc1Addr[l*PREG_W +: PREG_W], WakeValid, WakeAddr, sw_v, sw_tag);
      lane_s2_hit[l] = tag_hit(InSrc2Addr[l*PREG_W +: PREG_W], WakeValid, WakeAddr, sw_v, sw_tag);
    end
    for (int e = 0; e < DEPTH; e++) begin
      ent_s1_hit[e] = tag_hit(s1_tag[e], WakeValid, WakeAddr, sw_v, sw_tag);
      ent_s2_hit[e] = tag_hit(s2_tag[e], WakeValid, WakeAddr, sw_v, sw_tag);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rest || IsQuFlash) begin
      ent_valid <= '0;
      s1_rdy    <= '0;
      s2_rdy    <= '0;
      occ       <= '0;
    end else begin
      occ <= occ + acc_cnt - CNT_W'(issue_fire);
      for (int e = 0; e < DEPTH; e++) begin
        if (wr_en[e]) begin
          ent_valid[e] <= 1'b1;
          s1_rdy[e]    <= InSrc1Rdy[wr_lane[e]] | lane_s1_hit[wr_lane[e]];
          s2_rdy[e]    <= InSrc2Rdy[wr_lane[e]] | lane_s2_hit[wr_lane[e]];
        end else if (issue_fire && (sel_idx == IDX_W'(e))) begin
          ent_valid[e] <= 1'b0;
        end else if (ent_valid[e]) begin
          if (s1_able[e] && ent_s1_hit[e]) s1_rdy[e] <= 1'b1;
          if (s2_able[e] && ent_s2_hit[e]) s2_rdy[e] <= 1'b1;
        end
      end
    end
  end

  // tag/payload storage carries no reset; valid bits qualify it
  always_ff @(posedge Clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_en[e]) begin
        s1_able[e] <= InSrc1Able[wr_lane[e]];
        s2_able[e] <= InSrc2Able[wr_lane[e]];
        rd_able[e] <= InRdAble[wr_lane[e]];
        s1_tag[e]  <= InSrc1Addr[wr_lane[e]*PREG_W +: PREG_W];
        s2_tag[e]  <= InSrc2Addr[wr_lane[e]*PREG_W +: PREG_W];
        rd_tag[e]  <= InRdAddr[wr_lane[e]*PREG_W +: PREG_W];
        pay[e]     <= InPayload[wr_lane[e]*PAY_W +: PAY_W];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// Scoreboard bench for issue_queue_param at default parameters: expected issues
// are queued at dispatch and compared as the DUT hands them downstream.
module tb_issue_queue_param;

  logic         Clk = 1'b0;
  logic         Rest;
  logic         IsQuStop;
  logic         IsQuFlash;
  logic         IsQuReq;
  logic [3:0]   InValid;
  logic [3:0]   InSrc1Able;
  logic [3:0]   InSrc2Able;
  logic [3:0]   InRdAble;
  logic [3:0]   InSrc1Rdy;
  logic [3:0]   InSrc2Rdy;
  logic [23:0]  InSrc1Addr;
  logic [23:0]  InSrc2Addr;
  logic [23:0]  InRdAddr;
  logic [139:0] InPayload;
  logic [3:0]   WakeValid;
  logic [23:0]  WakeAddr;
  logic         IssReady = 1'b0;
  logic         IssValid;
  logic [5:0]   IssSrc1Addr;
  logic [5:0]   IssSrc2Addr;
  logic [5:0]   IssRdAddr;
  logic         IssRdAble;
  logic [34:0]  IssPayload;
  logic [3:0]   IssEntry;
  logic [4:0]   Occupancy;

  typedef struct {
    logic [5:0]  rd;
    logic [34:0] pay;
    logic [3:0]  ent;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  issue_queue_param dut (
    .Clk(Clk), .Rest(Rest), .IsQuStop(IsQuStop), .IsQuFlash(IsQuFlash), .IsQuReq(IsQuReq),
    .InValid(InValid), .InSrc1Able(InSrc1Able), .InSrc2Able(InSrc2Able), .InRdAble(InRdAble),
    .InSrc1Rdy(InSrc1Rdy), .InSrc2Rdy(InSrc2Rdy), .InSrc1Addr(InSrc1Addr),
    .InSrc2Addr(InSrc2Addr), .InRdAddr(InRdAddr), .InPayload(InPayload),
    .WakeValid(WakeValid), .WakeAddr(WakeAddr), .IssReady(IssReady), .IssValid(IssValid),
    .IssSrc1Addr(IssSrc1Addr), .IssSrc2Addr(IssSrc2Addr), .IssRdAddr(IssRdAddr),
    .IssRdAble(IssRdAble), .IssPayload(IssPayload), .IssEntry(IssEntry), .Occupancy(Occupancy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    InValid = '0; InSrc1Able = '0; InSrc2Able = '0; InRdAble = '0;
    InSrc1Rdy = '0; InSrc2Rdy = '0; InSrc1Addr = '0; InSrc2Addr = '0;
    InRdAddr = '0; InPayload = '0; WakeValid = '0; WakeAddr = '0;
  endtask

  task automatic lane(input int l, input logic s1a, input logic s1r, input logic [5:0] s1,
                      input logic s2a, input logic s2r, input logic [5:0] s2,
                      input logic rda, input logic [5:0] rd, input logic [34:0] p);
    InValid[l] = 1'b1;
    InSrc1Able[l] = s1a; InSrc1Rdy[l] = s1r; InSrc1Addr[l*6 +: 6] = s1;
    InSrc2Able[l] = s2a; InSrc2Rdy[l] = s2r; InSrc2Addr[l*6 +: 6] = s2;
    InRdAble[l] = rda; InRdAddr[l*6 +: 6] = rd; InPayload[l*35 +: 35] = p;
  endtask

  task automatic sb_push(input logic [5:0] rd, input logic [34:0] p, input logic [3:0] ent);
    exp_t x;
    x.rd = rd; x.pay = p; x.ent = ent;
    sb.push_back(x);
  endtask

  // n ready instructions, four lanes per cycle, into an empty queue
  task automatic fill(input int n, input bit do_push);
    int k;
    k = 0;
    while (k < n) begin
      clear_in();
      for (int l = 0; l < 4 && k < n; l++) begin
        lane(l, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'(10 + k), 35'h1_0000_0000 + 35'(k));
        if (do_push) sb_push(6'(10 + k), 35'h1_0000_0000 + 35'(k), 4'(k));
        k++;
      end
      tick();
    end
    clear_in();
  endtask

  // a handshake completes at the next rising edge; check it mid-cycle
  always @(negedge Clk) begin
    if (IssValid === 1'b1 && IssReady === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'(IssEntry), 64'hdead);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("iss_rd", 64'(IssRdAddr), 64'(x.rd));
        chk("iss_payload", 64'(IssPayload), 64'(x.pay));
        chk("iss_entry", 64'(IssEntry), 64'(x.ent));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    Rest = 1'b0; IsQuStop = 1'b0; IsQuFlash = 1'b0; IssReady = 1'b0;
    tick(); tick();
    chk("rst_occ", 64'(Occupancy), 64'd0);
    chk("rst_req", 64'(IsQuReq), 64'd0);
    chk("rst_issvalid", 64'(IssValid), 64'd0);
    Rest = 1'b1;

    // four ready lanes drain in entry order, one per cycle
    IssReady = 1'b1;
    for (int l = 0; l < 4; l++) begin
      lane(l, 1'b1, 1'b1, 6'(20 + l), 1'b1, 1'b1, 6'(30 + l), 1'b1, 6'(1 + l), 35'(100 + l));
      sb_push(6'(1 + l), 35'(100 + l), 4'(l));
    end
    #1;
    chk("disp_cycle_issvalid", 64'(IssValid), 64'd0);
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_occ", 64'(Occupancy), 64'(4 - i));
      chk("drain_issvalid", 64'(IssValid), 64'd1);
      tick();
    end
    chk("drain_occ_end", 64'(Occupancy), 64'd0);
    chk("drain_issvalid_end", 64'(IssValid), 64'd0);

    // backpressure at 13 of 16
    IssReady = 1'b0;
    fill(13, 1'b1);
    chk("fill_occ", 64'(Occupancy), 64'd13);
    chk("fill_req", 64'(IsQuReq), 64'd1);
    for (int l = 0; l < 4; l++)
      lane(l, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'(50 + l), 35'(200 + l));
    tick();
    clear_in();
    chk("drop_occ", 64'(Occupancy), 64'd13);
    IssReady = 1'b1;
    tick();
    IssReady = 1'b0;
    chk("after_issue_occ", 64'(Occupancy), 64'd12);
    chk("after_issue_req", 64'(IsQuReq), 64'd0);
    IssReady = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    IssReady = 1'b0;
    chk("bp_drained_occ", 64'(Occupancy), 64'd0);

    // wakeup on src1 = 9, with a same-cycle dispatch bypass
    lane(0, 1'b1, 1'b0, 6'd9, 1'b0, 1'b0, 6'd0, 1'b1, 6'd30, 35'h3_0000_0030);
    sb_push(6'd30, 35'h3_0000_0030, 4'd0);
    tick();
    clear_in();
    WakeValid[0] = 1'b1; WakeAddr[5:0] = 6'd8;
    #1;
    chk("wait_issvalid", 64'(IssValid), 64'd0);
    tick();
    clear_in();
    #1;
    chk("wrong_tag_issvalid", 64'(IssValid), 64'd0);
    WakeValid[2] = 1'b1; WakeAddr[17:12] = 6'd9;
    lane(0, 1'b1, 1'b0, 6'd9, 1'b0, 1'b0, 6'd0, 1'b1, 6'd31, 35'h3_0000_0031);
    sb_push(6'd31, 35'h3_0000_0031, 4'd1);
    tick();
    clear_in();
    IssReady = 1'b1;
    #1;
    chk("woken_issvalid", 64'(IssValid), 64'd1);
    tick();
    #1;
    chk("bypass_issvalid", 64'(IssValid), 64'd1);
    tick();
    chk("wake_done_issvalid", 64'(IssValid), 64'd0);

    // self-wake: A (rd 5) then B (src2 5) on back-to-back cycles
    lane(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd5, 35'h5_0000_0005);
    lane(1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd5, 1'b1, 6'd6, 35'h5_0000_0006);
    sb_push(6'd5, 35'h5_0000_0005, 4'd0);
    sb_push(6'd6, 35'h5_0000_0006, 4'd1);
    tick();
    clear_in();
    #1;
    chk("self_a_issvalid", 64'(IssValid), 64'd1);
    tick();
    #1;
    chk("self_b_issvalid", 64'(IssValid), 64'd1);
    tick();
    chk("self_done_issvalid", 64'(IssValid), 64'd0);

    // self-wake reaching a lane dispatched while C issues
    lane(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd7, 35'h7_0000_0007);
    sb_push(6'd7, 35'h7_0000_0007, 4'd0);
    tick();
    clear_in();
    lane(0, 1'b1, 1'b0, 6'd7, 1'b0, 1'b0, 6'd0, 1'b1, 6'd8, 35'h7_0000_0008);
    sb_push(6'd8, 35'h7_0000_0008, 4'd1);
    tick();
    clear_in();
    #1;
    chk("self_bypass_issvalid", 64'(IssValid), 64'd1);
    tick();
    chk("self_bypass_done", 64'(IssValid), 64'd0);

    // stall: no issue, dispatch dropped, wakeup retained
    IssReady = 1'b0;
    lane(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd40, 35'h4_0000_0040);
    lane(1, 1'b1, 1'b0, 6'd12, 1'b0, 1'b0, 6'd0, 1'b1, 6'd41, 35'h4_0000_0041);
    sb_push(6'd40, 35'h4_0000_0040, 4'd0);
    sb_push(6'd41, 35'h4_0000_0041, 4'd1);
    tick();
    clear_in();
    IsQuStop = 1'b1; IssReady = 1'b1;
    lane(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd42, 35'h4_0000_0042);
    WakeValid[1] = 1'b1; WakeAddr[11:6] = 6'd12;
    #1;
    chk("stall_issvalid", 64'(IssValid), 64'd0);
    tick();
    clear_in();
    #1;
    chk("stall2_issvalid", 64'(IssValid), 64'd0);
    tick();
    chk("stall_occ", 64'(Occupancy), 64'd2);
    IsQuStop = 1'b0;
    #1;
    chk("release_e_issvalid", 64'(IssValid), 64'd1);
    tick();
    #1;
    chk("release_f_issvalid", 64'(IssValid), 64'd1);
    tick();
    chk("stall_done_occ", 64'(Occupancy), 64'd0);

    // flash with 10 entries and a simultaneous 4-lane dispatch
    IssReady = 1'b0;
    fill(10, 1'b0);
    chk("pre_flash_occ", 64'(Occupancy), 64'd10);
    IsQuFlash = 1'b1;
    for (int l = 0; l < 4; l++)
      lane(l, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'(60 + l), 35'(300 + l));
    #1;
    chk("flash_cycle_issvalid", 64'(IssValid), 64'd1);
    tick();
    IsQuFlash = 1'b0;
    clear_in();
    IssReady = 1'b1;
    chk("flash_occ", 64'(Occupancy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_flash_issvalid", 64'(IssValid), 64'd0);
      tick();
    end

    // reset mid-operation discards everything, even with a dispatch pending
    IssReady = 1'b0;
    fill(3, 1'b0);
    chk("pre_rst_occ", 64'(Occupancy), 64'd3);
    Rest = 1'b0;
    lane(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd0, 35'd0);
    tick();
    clear_in();
    Rest = 1'b1;
    IssReady = 1'b1;
    #1;
    chk("mid_rst_occ", 64'(Occupancy), 64'd0);
    chk("mid_rst_req", 64'(IsQuReq), 64'd0);
    chk("mid_rst_issvalid", 64'(IssValid), 64'd0);
    tick();
    chk("mid_rst_issvalid2", 64'(IssValid), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
